// File: rtl/mux_case_diff_pkg.sv
// Package: mux_case_diff_pkg
// Purpose: shared constants for the registered byte selector/subtractor.
//   WIDTH_DEFAULT : default operand/result width
//   SEL_*         : operation select encodings for the s input
package mux_case_diff_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    localparam logic [1:0] SEL_A   = 2'b00;  // out <= a_in
    localparam logic [1:0] SEL_B   = 2'b01;  // out <= b_in
    localparam logic [1:0] SEL_AMB = 2'b10;  // out <= a_in - b_in (wraps)
    localparam logic [1:0] SEL_BMA = 2'b11;  // out <= b_in - a_in (wraps)

endpackage

// File: rtl/mux_case_diff.sv
// Module: mux_case_diff
// Purpose: registered 4-way selector/subtractor. A 2-bit select picks a_in, b_in,
//   a_in-b_in or b_in-a_in (modulo 2**WIDTH). The result is captured on the rising
//   clock edge, giving exactly one cycle of latency.
// Ports (positional order is fixed for legacy instantiations):
//   a_in [WIDTH-1:0] in  : operand A
//   b_in [WIDTH-1:0] in  : operand B
//   s    [1:0]       in  : operation select (see mux_case_diff_pkg SEL_*)
//   clk              in  : rising-edge clock
//   out  [WIDTH-1:0] out : registered result
//   rst              in  : synchronous active-high reset, clears out
module mux_case_diff
    import mux_case_diff_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [1:0]       s,
    input  logic             clk,
    output logic [WIDTH-1:0] out,
    input  logic             rst
);

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;

    // Subtractions are WIDTH bits wide, so the borrow is simply dropped.
    always_comb begin
        out_d = '0;
        case (s)
            SEL_A:   out_d = a_in;
            SEL_B:   out_d = b_in;
            SEL_AMB: out_d = a_in - b_in;
            SEL_BMA: out_d = b_in - a_in;
            // Only reachable in simulation with X/Z on s.
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_mux_case_diff.sv
// Testbench for mux_case_diff: directed cases plus randomized stimulus checked
// against an arithmetic reference model.
module tb_mux_case_diff;

    logic       clk;
    logic       rst;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [1:0] s;
    logic [7:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    mux_case_diff #(.WIDTH(8)) dut (
        .a_in (a_in),
        .b_in (b_in),
        .s    (s),
        .clk  (clk),
        .out  (out),
        .rst  (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, reduced modulo 256.
    function automatic logic [7:0] ref_f(input logic [1:0] sel, input logic [7:0] a,
                                         input logic [7:0] b);
        int ia;
        int ib;
        int r;
        ia = int'(a);
        ib = int'(b);
        case (sel)
            2'd0:    r = ia;
            2'd1:    r = ib;
            2'd2:    r = (ia - ib + 256) % 256;
            default: r = (ib - ia + 256) % 256;
        endcase
        return 8'(r);
    endfunction

    // Advance past one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        a_in = 8'h3C;
        b_in = 8'hC3;
        s    = 2'b11;
        tick();
        tick();
        n_checks++;
        if (out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: out=%h expected=%h", out, 8'h00);
        end
        rst = 1'b0;
    endtask

    task automatic test_select();
        a_in = 8'h0A;
        b_in = 8'hAC;
        s    = 2'b00;
        tick();
        n_checks++;
        if (out !== 8'h0A) begin
            n_fail++;
            $display("FAIL select_a: out=%h expected=%h", out, 8'h0A);
        end
        s = 2'b01;
        tick();
        n_checks++;
        if (out !== 8'hAC) begin
            n_fail++;
            $display("FAIL select_b: out=%h expected=%h", out, 8'hAC);
        end
    endtask

    task automatic test_subtract();
        a_in = 8'h0A;
        b_in = 8'hAC;
        s    = 2'b10;
        tick();
        n_checks++;
        if (out !== 8'h5E) begin
            n_fail++;
            $display("FAIL sub_amb: out=%h expected=%h", out, 8'h5E);
        end
        s = 2'b11;
        tick();
        n_checks++;
        if (out !== 8'hA2) begin
            n_fail++;
            $display("FAIL sub_bma: out=%h expected=%h", out, 8'hA2);
        end
    endtask

    task automatic test_boundary();
        a_in = 8'h00;
        b_in = 8'h01;
        s    = 2'b10;
        tick();
        n_checks++;
        if (out !== 8'hFF) begin
            n_fail++;
            $display("FAIL boundary_wrap: out=%h expected=%h", out, 8'hFF);
        end
        a_in = 8'hFF;
        b_in = 8'hFF;
        s    = 2'b11;
        tick();
        n_checks++;
        if (out !== 8'h00) begin
            n_fail++;
            $display("FAIL boundary_equal: out=%h expected=%h", out, 8'h00);
        end
    endtask

    task automatic test_latency();
        s    = 2'b00;
        a_in = 8'h11;
        b_in = 8'h99;
        tick();
        n_checks++;
        if (out !== 8'h11) begin
            n_fail++;
            $display("FAIL latency_first: out=%h expected=%h", out, 8'h11);
        end
        #3;
        a_in = 8'h22;
        #3;
        n_checks++;
        if (out !== 8'h11) begin
            n_fail++;
            $display("FAIL latency_hold: out=%h expected=%h", out, 8'h11);
        end
        tick();
        n_checks++;
        if (out !== 8'h22) begin
            n_fail++;
            $display("FAIL latency_update: out=%h expected=%h", out, 8'h22);
        end
    endtask

    task automatic test_reset_midop();
        s    = 2'b01;
        b_in = 8'h55;
        a_in = 8'h07;
        tick();
        n_checks++;
        if (out !== 8'h55) begin
            n_fail++;
            $display("FAIL midop_run: out=%h expected=%h", out, 8'h55);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (out !== 8'h00) begin
            n_fail++;
            $display("FAIL midop_reset: out=%h expected=%h", out, 8'h00);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (out !== 8'h55) begin
            n_fail++;
            $display("FAIL midop_resume: out=%h expected=%h", out, 8'h55);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_v;
        for (int i = 0; i < 300; i++) begin
            a_in = 8'($urandom_range(255, 0));
            b_in = 8'($urandom_range(255, 0));
            s    = 2'($urandom_range(3, 0));
            rst  = ($urandom_range(7, 0) == 0);
            exp_v = rst ? 8'h00 : ref_f(s, a_in, b_in);
            tick();
            n_checks++;
            if (out !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: rst=%b s=%b a=%h b=%h out=%h expected=%h",
                         i, rst, s, a_in, b_in, out, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        a_in = 8'h00;
        b_in = 8'h00;
        s    = 2'b00;
        test_reset();
        test_select();
        test_subtract();
        test_boundary();
        test_latency();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
